// File: rtl/rofofo_mem_pkg.sv
// Shared state encoding and geometry helpers for the
// wide-word to narrow-memory bridge.
package rofofo_mem_pkg;

  localparam int WORD_SIZE_DEF      = 256;
  localparam int ADDR_WIDTH_DEF     = 32;
  localparam int MEM_DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    ACK
  } state_t;

  function automatic int beats_f(
    input int ws,
    input int mdw
  );
    return ws / mdw;
  endfunction

  function automatic int beat_bytes_f(
    input int mdw
  );
    return mdw / 8;
  endfunction

  function automatic int offset_f(
    input int ws
  );
    return $clog2(ws / 8);
  endfunction

  function automatic int cnt_w_f(
    input int beats
  );
    return $clog2(beats + 1);
  endfunction

  function automatic int idx_w_f(
    input int beats
  );
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/wide_word_mem_bridge.sv
// Wishbone slave that splits each wide word access into
// a sequence of narrow memory beats, one transaction at a time.
module wide_word_mem_bridge
  import rofofo_mem_pkg::*;
#(
  parameter int WORD_SIZE      = WORD_SIZE_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  output logic                      wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]     wb_addr_i,
  input  logic [WORD_SIZE-1:0]      wb_mosi_i,
  output logic [WORD_SIZE-1:0]      wb_miso_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_rvalid_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int BEATS =
    beats_f(WORD_SIZE, MEM_DATA_WIDTH);
  localparam int BEAT_BYTES =
    beat_bytes_f(MEM_DATA_WIDTH);
  localparam int OFFSET = offset_f(WORD_SIZE);
  localparam int CW     = cnt_w_f(BEATS);
  localparam int IW     = idx_w_f(BEATS);

  localparam logic [CW-1:0] LAST   = CW'(BEATS - 1);
  localparam logic [CW-1:0] NBEATS = CW'(BEATS);

  typedef logic [BEATS-1:0][MEM_DATA_WIDTH-1:0] word_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_base;
  word_t                 r_wdata;
  word_t                 r_rbuf;
  word_t                 r_miso;
  word_t                 w_rbuf;
  logic [CW-1:0]         r_issue;
  logic [CW-1:0]         r_rcv;

  logic                  w_start;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_rx;
  logic                  w_wr_done;
  logic                  w_rd_done;
  logic [IW-1:0]         w_iidx;
  logic [IW-1:0]         w_ridx;
  logic [ADDR_WIDTH-1:0] w_beat_addr;
  logic                  w_unused;

  // Sub-word offset bits never reach the memory side.
  assign w_unused = ^wb_addr_i[OFFSET-1:0];

  assign w_start = wb_cyc_i && wb_stb_i;
  assign w_iidx  = r_issue[IW-1:0];
  assign w_ridx  = r_rcv[IW-1:0];

  assign w_req = (r_state == WRITE) ||
                 ((r_state == READ) &&
                  (r_issue != NBEATS));

  assign w_accept = w_req && mem_ready_i;

  // A beat may return in the very cycle it is accepted.
  assign w_rx = (r_state == READ) &&
                mem_rvalid_i &&
                (r_rcv != NBEATS) &&
                ((r_rcv < r_issue) || w_accept);

  assign w_wr_done = (r_state == WRITE) &&
                     w_accept &&
                     (r_issue == LAST);

  assign w_rd_done = w_rx && (r_rcv == LAST);

  assign w_beat_addr =
    r_base +
    (ADDR_WIDTH'(r_issue) * ADDR_WIDTH'(BEAT_BYTES));

  assign mem_req_o   = w_req;
  assign mem_we_o    = (r_state == WRITE);
  assign mem_addr_o  = w_req ? w_beat_addr : '0;
  assign mem_wdata_o = (r_state == WRITE) ?
                       r_wdata[w_iidx] : '0;
  assign wb_ack_o    = (r_state == ACK) && wb_cyc_i;
  assign wb_miso_o   = r_miso;

  always_comb begin
    w_rbuf = r_rbuf;
    if (w_rx) begin
      w_rbuf[w_ridx] = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next = wb_we_i ? WRITE : READ;
        end
      end
      WRITE: begin
        if (w_wr_done) begin
          w_next = ACK;
        end
      end
      READ: begin
        if (w_rd_done) begin
          w_next = ACK;
        end
      end
      ACK: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_miso  <= '0;
      r_issue <= '0;
      r_rcv   <= '0;
    end else if ((r_state == IDLE) && w_start) begin
      r_base  <= {wb_addr_i[ADDR_WIDTH-1:OFFSET],
                  {OFFSET{1'b0}}};
      r_wdata <= wb_mosi_i;
      r_issue <= '0;
      r_rcv   <= '0;
    end else begin
      if (w_accept) begin
        r_issue <= r_issue + CW'(1);
      end
      if (w_rx) begin
        r_rcv  <= r_rcv + CW'(1);
        r_rbuf <= w_rbuf;
      end
      if (w_rd_done) begin
        r_miso <= w_rbuf;
      end
    end
  end

endmodule

// File: tb/tb_wide_word_mem_bridge.sv
// Directed and randomized bench for the wide-word bridge
// with a queue-based memory responder and word-level model.
module tb_wide_word_mem_bridge;

  localparam int WS    = 256;
  localparam int AW    = 32;
  localparam int MW    = 32;
  localparam int BEATS = WS / MW;
  localparam int LIMIT = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic          wb_ack_o;
  logic [AW-1:0] wb_addr_i;
  logic [WS-1:0] wb_mosi_i;
  logic [WS-1:0] wb_miso_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [MW-1:0] mem_wdata_o;
  logic          mem_ready_i;
  logic          mem_rvalid_i;
  logic [MW-1:0] mem_rdata_i;

  wide_word_mem_bridge #(
    .WORD_SIZE(WS),
    .ADDR_WIDTH(AW),
    .MEM_DATA_WIDTH(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o),
    .wb_addr_i(wb_addr_i),
    .wb_mosi_i(wb_mosi_i),
    .wb_miso_o(wb_miso_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  task automatic chk(
    input string      tag,
    input logic [255:0] obs,
    input logic [255:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] d;
  } rv_t;

  rv_t         pend[$];
  logic [31:0] acc_addr[$];
  bit          acc_we[$];
  logic [31:0] acc_wd[$];
  logic [31:0] rd_log[$];

  bit          rand_mode = 1'b0;
  bit          stray     = 1'b0;
  int          acc_base  = 0;
  int          last_due  = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_wd;
  logic        prev_we;

  // Memory responder: ready, accepted-beat log, in-order rvalid.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      pend.delete();
      mem_ready_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      prev_stall   = 1'b0;
      last_due     = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_req", mem_req_o, 1'b1);
        chk("stall_addr", mem_addr_o, prev_addr);
        chk("stall_we", mem_we_o, prev_we);
        chk("stall_wd", mem_wdata_o, prev_wd);
      end
      mem_ready_i = rand_mode ?
        ($urandom_range(0, 1) == 1) : 1'b1;
      if (mem_req_o && mem_ready_i) begin
        int          due;
        logic [31:0] rd;
        acc_addr.push_back(mem_addr_o);
        acc_we.push_back(mem_we_o);
        acc_wd.push_back(mem_wdata_o);
        if (!mem_we_o) begin
          rd = rand_mode ? $urandom() :
               32'hA0 + 32'(acc_addr.size() - 1 - acc_base);
          due = cyc + (rand_mode ?
                int'($urandom_range(0, 5)) : 1);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{due, rd});
          rd_log.push_back(rd);
        end
      end
      prev_stall = mem_req_o && !mem_ready_i;
      prev_addr  = mem_addr_o;
      prev_wd    = mem_wdata_o;
      prev_we    = mem_we_o;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (stray) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        stray        = 1'b0;
      end else if (pend.size() > 0 &&
                   pend[0].due <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pend[0].d;
        void'(pend.pop_front());
      end
    end
  end

  int            ack_cnt = 0;
  int            ack_cyc = 0;
  logic [WS-1:0] ack_data;
  bit            x_seen = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if ($isunknown({mem_req_o, mem_we_o,
                      mem_addr_o, mem_wdata_o,
                      wb_ack_o, wb_miso_o}))
        x_seen = 1'b1;
      if (wb_ack_o) begin
        ack_cnt++;
        ack_cyc  = cyc;
        ack_data = wb_miso_o;
      end
    end
  end

  logic [WS-1:0] last_miso = '0;

  task automatic do_txn(
    input  bit            we,
    input  logic [AW-1:0] addr,
    input  logic [WS-1:0] data,
    input  int            drop_after,
    output int            lat
  );
    int            a0;
    int            c0;
    int            n;
    int            rd_base;
    int            nb;
    logic [31:0]   base;
    logic [WS-1:0] exp_w;
    @(negedge clk);
    acc_base  = acc_addr.size();
    rd_base   = rd_log.size();
    a0        = ack_cnt;
    c0        = cyc;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_we_i   = we;
    wb_addr_i = addr;
    wb_mosi_i = data;
    lat = -1;
    n   = 0;
    while (n < LIMIT) begin
      @(negedge clk);
      #3;
      n++;
      if (wb_ack_o) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        lat = cyc - c0;
        break;
      end
      if (drop_after >= 0 &&
          acc_addr.size() - acc_base >= drop_after) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
      if (!wb_cyc_i &&
          acc_addr.size() - acc_base >= BEATS)
        break;
    end
    chk("done_in_time", n < LIMIT, 1'b1);
    repeat (3) @(negedge clk);
    nb = acc_addr.size() - acc_base;
    chk("beat_count", nb, BEATS);
    chk("ack_count", ack_cnt - a0,
        (drop_after >= 0) ? 0 : 1);
    base = addr & ~32'h1F;
    for (int k = 0; k < BEATS; k++) begin
      if (acc_base + k < acc_addr.size()) begin
        chk($sformatf("addr%0d", k),
            acc_addr[acc_base + k],
            base + 32'(4 * k));
        chk($sformatf("we%0d", k),
            acc_we[acc_base + k], we);
        if (we)
          chk($sformatf("wd%0d", k),
              acc_wd[acc_base + k],
              data[32 * k +: 32]);
      end
    end
    if (!we) begin
      chk("rd_beats", rd_log.size() - rd_base, BEATS);
      exp_w = '0;
      for (int k = 0; k < BEATS; k++)
        if (rd_base + k < rd_log.size())
          exp_w[32 * k +: 32] = rd_log[rd_base + k];
      chk("rd_word", ack_data, exp_w);
      last_miso = exp_w;
    end
    chk("miso_hold", wb_miso_o, last_miso);
  endtask

  initial begin
    int            lat;
    int            n;
    int            a0;
    logic [WS-1:0] d;
    rst       = 1'b0;
    wb_cyc_i  = 1'b0;
    wb_stb_i  = 1'b0;
    wb_we_i   = 1'b0;
    wb_addr_i = '0;
    wb_mosi_i = '0;
    #3 rst = 1'b1;
    #4;
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wd", mem_wdata_o, 32'h0);
    chk("rst_ack", wb_ack_o, 1'b0);
    chk("rst_miso", wb_miso_o, 256'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 32; i++) d[8 * i +: 8] = 8'(i);
    do_txn(1'b1, 32'h1000, d, -1, lat);
    chk("wr_latency", lat, 9);

    do_txn(1'b0, 32'h2004, d, -1, lat);
    chk("rd_latency", lat, 10);

    do_txn(1'b0, 32'hFFFFFFE0, d, -1, lat);
    chk("wrap_latency", lat, 10);

    for (int i = 0; i < 8; i++) d[32 * i +: 32] = $urandom();
    do_txn(1'b1, 32'h4008, d, 4, lat);

    rand_mode = 1'b1;
    repeat (10) begin
      for (int i = 0; i < 8; i++)
        d[32 * i +: 32] = $urandom();
      do_txn($urandom_range(0, 1) == 1,
             $urandom(), d, -1, lat);
    end
    rand_mode = 1'b0;

    @(negedge clk);
    acc_base  = acc_addr.size();
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_we_i   = 1'b0;
    wb_addr_i = 32'h3000;
    n = 0;
    while (acc_addr.size() - acc_base < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_beats",
        acc_addr.size() - acc_base >= 4, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", mem_req_o, 1'b0);
    chk("mid_rst_addr", mem_addr_o, 32'h0);
    chk("mid_rst_wd", mem_wdata_o, 32'h0);
    chk("mid_rst_ack", wb_ack_o, 1'b0);
    chk("mid_rst_miso", wb_miso_o, 256'h0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    last_miso = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    a0 = ack_cnt;
    @(negedge clk);
    stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_noack", ack_cnt - a0, 0);
    chk("stray_noreq", mem_req_o, 1'b0);
    do_txn(1'b0, 32'h3010, d, -1, lat);
    chk("post_rst_latency", lat, 10);

    chk("no_x_bus", x_seen, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
